beep_driver: RTL and testbench



---
 rtl/ui_pkg.sv | 23 ++
 rtl/tick_gen.sv | 27 ++
 rtl/beep_driver.sv | 140 ++++++++++++++
 tb/tb_beep_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ui_pkg.sv
// Shared UI definitions: feedback FSM states, default board timing and a
// counter-width helper used by the dividers.
package ui_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BEEP = 2'd1,
      GAP  = 2'd2
   } ui_state_e;

   // 27 MHz board clock: 100 Hz timing tick, 2 kHz buzzer tone
   localparam int DEF_TICK_DIV   = 270000;
   localparam int DEF_TONE_DIV   = 6750;
   localparam int DEF_BEEP_TICKS = 10;
   localparam int DEF_GAP_TICKS  = 5;
   localparam int DEF_QUEUE_MAX  = 7;

   // Width of a counter holding 0..n-1; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider producing a one-cycle tick every DIV clocks.
// Only reset re-phases it, so every consumer sees the same tick grid.
module tick_gen
   import ui_pkg::*;
#(
   parameter int DIV = DEF_TICK_DIV
)(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int            W    = cnt_w(DIV);
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] count;

   // wrap at DIV-1, zero on reset
   always_ff @(posedge clk) begin
      if (rst)                count <= '0;
      else if (count == LAST) count <= '0;
      else                    count <= count + 1'b1;
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/beep_driver.sv
// Feedback driver: each request gives one timed beep (tone + LED) followed
// by a silent gap; requests arriving mid-beep/gap are queued and replayed.
module beep_driver
   import ui_pkg::*;
#(
   parameter int TICK_DIV   = DEF_TICK_DIV,
   parameter int TONE_DIV   = DEF_TONE_DIV,
   parameter int BEEP_TICKS = DEF_BEEP_TICKS,
   parameter int GAP_TICKS  = DEF_GAP_TICKS,
   parameter int QUEUE_MAX  = DEF_QUEUE_MAX
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trig,
   output logic                           buzzer,
   output logic                           led,
   output logic                           busy,
   output logic [$clog2(QUEUE_MAX+1)-1:0] pending,
   output logic                           overflow
);

   localparam int PW = $clog2(QUEUE_MAX + 1);
   localparam int TW = cnt_w((BEEP_TICKS > GAP_TICKS) ? BEEP_TICKS : GAP_TICKS);
   localparam int OW = cnt_w(TONE_DIV);

   localparam logic [PW-1:0] QMAX      = PW'(QUEUE_MAX);
   localparam logic [TW-1:0] BEEP_LAST = TW'(BEEP_TICKS - 1);
   localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
   localparam logic [OW-1:0] TONE_LAST = OW'(TONE_DIV - 1);

   logic          tick;
   ui_state_e     state, state_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic [PW-1:0] pend_nx;
   logic [PW-1:0] pend_inc;
   logic          full_drop;
   logic          drop;
   logic          tone_run;
   logic [OW-1:0] tone_cnt;

   tick_gen #(.DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // plain enqueue outcome for a trig that does not coincide with a dequeue
   assign full_drop = (pending == QMAX);
   assign pend_inc  = full_drop ? pending : pending + 1'b1;

   // next state, phase counter and queue depth
   always_comb begin
      state_nx = state;
      tcnt_nx  = tcnt;
      pend_nx  = pending;
      drop     = 1'b0;
      case (state)
         IDLE: begin
            if (trig || pending != '0) begin
               state_nx = BEEP;
               tcnt_nx  = '0;
               // a direct accept bypasses the queue; a queued start with a
               // simultaneous trig swaps one entry for another
               if (pending != '0 && !trig) pend_nx = pending - 1'b1;
            end
         end
         BEEP: begin
            if (tick) begin
               if (tcnt == BEEP_LAST) begin
                  state_nx = GAP;
                  tcnt_nx  = '0;
               end else begin
                  tcnt_nx  = tcnt + 1'b1;
               end
            end
            if (trig) begin
               pend_nx = pend_inc;
               drop    = full_drop;
            end
         end
         GAP: begin
            if (tick && tcnt == GAP_LAST) begin
               tcnt_nx = '0;
               if (pending != '0) begin
                  // dequeue frees a slot, so a coincident trig never drops
                  state_nx = BEEP;
                  if (!trig) pend_nx = pending - 1'b1;
               end else begin
                  // a trig on the way out is queued and restarts from IDLE
                  state_nx = IDLE;
                  if (trig) pend_nx = pending + 1'b1;
               end
            end else begin
               if (tick) tcnt_nx = tcnt + 1'b1;
               if (trig) begin
                  pend_nx = pend_inc;
                  drop    = full_drop;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // FSM, queue and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tcnt     <= '0;
         pending  <= '0;
         overflow <= 1'b0;
         led      <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         tcnt     <= tcnt_nx;
         pending  <= pend_nx;
         overflow <= drop;
         led      <= (state_nx == BEEP);
         busy     <= (state_nx != IDLE);
      end
   end

   // tone only advances while staying in BEEP, so entry always starts at 0/low
   assign tone_run = (state == BEEP) && (state_nx == BEEP);

   // buzzer half-period divider
   always_ff @(posedge clk) begin
      if (rst || !tone_run) begin
         tone_cnt <= '0;
         buzzer   <= 1'b0;
      end else if (tone_cnt == TONE_LAST) begin
         tone_cnt <= '0;
         buzzer   <= ~buzzer;
      end else begin
         tone_cnt <= tone_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_beep_driver.sv
// Directed bench for beep_driver with small timing parameters.
// Expected beeps, pending-count changes and overflow pulses are queued at
// stimulus time; the negedge monitor pops and compares as the DUT emits them.
module tb_beep_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       trig = 1'b0;
   logic       buzzer, led, busy, overflow;
   logic [1:0] pending;

   int errors = 0;
   int checks = 0;
   int ecnt = 0;   // edges since reset release; tick edges are ecnt % 4 == 0

   typedef struct {
      int          len;
      logic [15:0] pat;
   } beep_t;

   beep_t      bq[$];
   logic [1:0] pq[$];
   bit         oq[$];

   beep_driver #(
      .TICK_DIV(4), .TONE_DIV(2), .BEEP_TICKS(2), .GAP_TICKS(1), .QUEUE_MAX(2)
   ) dut (
      .clk(clk), .rst(rst), .trig(trig), .buzzer(buzzer), .led(led),
      .busy(busy), .pending(pending), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) ecnt <= 0;
      else     ecnt <= ecnt + 1;
   end

   // monitor / scoreboard
   logic        prev_led  = 1'b0;
   logic [1:0]  prev_pend = 2'd0;
   int          cur_len   = 0;
   logic [15:0] cur_pat   = '0;
   beep_t       bexp;
   logic [1:0]  pexp;
   bit          odum;

   always @(negedge clk) begin
      if (led === 1'b1) begin
         if (prev_led !== 1'b1) begin
            cur_len = 0;
            cur_pat = '0;
         end
         cur_len++;
         cur_pat = {cur_pat[14:0], buzzer};
      end else if (prev_led === 1'b1) begin
         checks++;
         if (bq.size() == 0) begin
            errors++;
            $display("FAIL beep: unexpected beep len=%0d pat=%0h", cur_len, cur_pat);
         end else begin
            bexp = bq.pop_front();
            if (cur_len != bexp.len || cur_pat !== bexp.pat) begin
               errors++;
               $display("FAIL beep: got len=%0d pat=%0h expected len=%0d pat=%0h",
                        cur_len, cur_pat, bexp.len, bexp.pat);
            end
         end
      end
      prev_led = led;

      if (pending !== prev_pend) begin
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL pending: unexpected change %0d -> %0d", prev_pend, pending);
         end else begin
            pexp = pq.pop_front();
            if (pending !== pexp) begin
               errors++;
               $display("FAIL pending: got %0d expected %0d", pending, pexp);
            end
         end
      end
      prev_pend = pending;

      if (overflow !== 1'b0) begin
         checks++;
         if (oq.size() == 0) begin
            errors++;
            $display("FAIL overflow: unexpected pulse value=%b", overflow);
         end else begin
            odum = oq.pop_front();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // trig sampled on the next edge; returns 1 time unit after that edge
   task automatic fire();
      trig = 1'b1;
      cyc(1);
      trig = 1'b0;
   endtask

   // position so the next edge is a tick edge
   task automatic align();
      while ((ecnt + 1) % 4 != 0) cyc(1);
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (busy !== 1'b0 && n < max) begin
         cyc(1);
         n++;
      end
      chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic push_std(input int n);
      beep_t b;
      b.len = 8;
      b.pat = 16'h0033;
      repeat (n) bq.push_back(b);
   endtask

   initial begin
      beep_t b;

      // reset
      cyc(2);
      chk("rst_led", {31'd0, led}, 0);
      chk("rst_buzzer", {31'd0, buzzer}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_pending", {30'd0, pending}, 0);
      chk("rst_overflow", {31'd0, overflow}, 0);
      rst = 1'b0;
      cyc(1);

      // single beep on a tick edge: 8-cycle beep, 4-cycle gap
      push_std(1);
      align();
      fire();
      chk("s1_led_on", {31'd0, led}, 1);
      chk("s1_busy_on", {31'd0, busy}, 1);
      cyc(11);
      chk("s1_gap_busy", {31'd0, busy}, 1);
      chk("s1_gap_led", {31'd0, led}, 0);
      cyc(1);
      chk("s1_idle_busy", {31'd0, busy}, 0);
      chk("s1_idle_pending", {30'd0, pending}, 0);

      // queued replay: three requests, one idle cycle apart
      push_std(3);
      pq.push_back(2'd1); pq.push_back(2'd2); pq.push_back(2'd1); pq.push_back(2'd0);
      align();
      fire();
      cyc(1); fire();
      cyc(1); fire();
      chk("s2_pending2", {30'd0, pending}, 2);
      wait_idle(200);
      chk("s2_end_pending", {30'd0, pending}, 0);

      // overflow: four extra requests during the first beep
      push_std(3);
      pq.push_back(2'd1); pq.push_back(2'd2); pq.push_back(2'd1); pq.push_back(2'd0);
      oq.push_back(1'b1); oq.push_back(1'b1);
      align();
      fire();
      fire();
      cyc(1); fire();
      cyc(1); fire();
      chk("s3_saturated", {30'd0, pending}, 2);
      cyc(1); fire();
      wait_idle(200);

      // trig on the GAP->BEEP dequeue edge with a full queue
      push_std(4);
      pq.push_back(2'd1); pq.push_back(2'd2); pq.push_back(2'd1); pq.push_back(2'd0);
      align();
      fire();          // E
      fire();          // E+1
      cyc(1); fire();  // E+3
      cyc(8); fire();  // E+12, gap end
      chk("s4a_pending", {30'd0, pending}, 2);
      chk("s4a_led", {31'd0, led}, 1);
      chk("s4a_no_ovf", {31'd0, overflow}, 0);
      wait_idle(300);

      // trig on the GAP->IDLE edge: queued, then restarted one cycle later
      push_std(1);
      b.len = 7; b.pat = 16'h0019;
      bq.push_back(b);
      pq.push_back(2'd1); pq.push_back(2'd0);
      align();
      fire();          // E
      cyc(11); fire(); // E+12
      chk("s4b_idle", {31'd0, busy}, 0);
      chk("s4b_pending", {30'd0, pending}, 1);
      cyc(1);
      chk("s4b_restart_led", {31'd0, led}, 1);
      wait_idle(200);

      // reset mid-beep with one request queued
      b.len = 5; b.pat = 16'h0006;
      bq.push_back(b);
      pq.push_back(2'd1); pq.push_back(2'd0);
      align();
      fire();          // E
      cyc(1); fire();  // E+2
      cyc(2);
      rst = 1'b1;
      cyc(1);          // reset sampled at E+5
      rst = 1'b0;
      chk("s5_led", {31'd0, led}, 0);
      chk("s5_buzzer", {31'd0, buzzer}, 0);
      chk("s5_busy", {31'd0, busy}, 0);
      chk("s5_pending", {30'd0, pending}, 0);
      chk("s5_overflow", {31'd0, overflow}, 0);
      cyc(30);
      chk("s5_no_replay", {31'd0, busy}, 0);
      // tick grid restarted: an aligned trig yields a full-length beep
      push_std(1);
      align();
      fire();
      wait_idle(100);

      cyc(2);
      chk("beep_q_empty", bq.size(), 0);
      chk("pend_q_empty", pq.size(), 0);
      chk("ovf_q_empty", oq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
